// File: rtl/tlc_pkg.sv
// Shared types for the signal-head phase scheduler:
// light codes, FSM states and phase-index arithmetic.
package tlc_pkg;

    localparam logic [1:0] LC_GREEN  = 2'd0;
    localparam logic [1:0] LC_YELLOW = 2'd1;
    localparam logic [1:0] LC_RED    = 2'd2;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } state_t;

    // (p + k) mod n on a 2-bit phase index
    function automatic logic [1:0] ph_add(
        input logic [1:0] p,
        input int         k,
        input int         n
    );
        int s;
        s = (int'(p) + k) % n;
        return s[1:0];
    endfunction

endpackage

// File: rtl/tlc_phase_sched_if.sv
// Controller-side bundle of the phase scheduler: timebase,
// mode and requests in; light codes and status out.
interface tlc_phase_sched_if #(
    parameter int N_PHASE = 3
);
    logic                   tick;
    logic                   peak;
    logic [N_PHASE-1:0]     req;
    logic [2*N_PHASE-1:0]   light;
    logic [1:0]             cur_phase;
    logic                   green_start;
    logic [N_PHASE-1:0]     pending;

    modport master (
        output tick, peak, req,
        input  light, cur_phase, green_start, pending
    );

    modport slave (
        input  tick, peak, req,
        output light, cur_phase, green_start, pending
    );
endinterface

// File: rtl/tlc_rr_pick.sv
// Round-robin first-set finder: lowest set bit of vec
// at or after start, wrapping; idx = start when none set.
module tlc_rr_pick
    import tlc_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] vec,
    input  logic [1:0]   start,
    output logic [1:0]   idx,
    output logic         found
);

    always_comb begin
        found = 1'b0;
        idx   = start;
        for (int k = 0; k < N; k++) begin
            if (!found && vec[ph_add(start, k, N)]) begin
                found = 1'b1;
                idx   = ph_add(start, k, N);
            end
        end
    end

endmodule

// File: rtl/tlc_phase_sched.sv
// Phase scheduler: peak fixed rotation or off-peak
// request-driven round-robin with min/max and rest-in-green.
module tlc_phase_sched
    import tlc_pkg::*;
#(
    parameter int N_PHASE    = 3,
    parameter int TW         = 6,
    parameter int GREEN_PEAK = 32,
    parameter int GREEN_MIN  = 16,
    parameter int GREEN_MAX  = 32,
    parameter int YELLOW     = 4,
    parameter int ALLRED     = 2
) (
    input  logic             clk,
    input  logic             reset,
    tlc_phase_sched_if.slave bus
);

    // A state of length D ends on the tick where timer == D-1
    localparam logic [TW-1:0] T_AR   = TW'(ALLRED - 1);
    localparam logic [TW-1:0] T_Y    = TW'(YELLOW - 1);
    localparam logic [TW-1:0] T_GP   = TW'(GREEN_PEAK - 1);
    localparam logic [TW-1:0] T_GMIN = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] T_GMAX = TW'(GREEN_MAX - 1);

    state_t               state, state_n;
    logic [TW-1:0]        timer, timer_n;
    logic [1:0]           cur, cur_n;
    logic [1:0]           ptr, ptr_n;
    logic [N_PHASE-1:0]   pend, pend_n;
    logic [2*N_PHASE-1:0] light, light_n;
    logic                 gs, gs_n;

    logic [1:0]           pick_idx;
    logic                 pick_found;
    logic                 other;
    logic                 own_req;
    logic                 green_done;

    tlc_rr_pick #(
        .N (N_PHASE)
    ) u_pick (
        .vec   (pend),
        .start (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        other   = 1'b0;
        own_req = 1'b0;
        for (int i = 0; i < N_PHASE; i++) begin
            if (2'(i) == cur)
                own_req = bus.req[i];
            else
                other = other | pend[i];
        end
    end

    assign green_done = bus.peak
        ? (timer >= T_GP)
        : (timer >= T_GMIN && other &&
           (!own_req || timer >= T_GMAX));

    always_comb begin
        state_n = state;
        timer_n = timer;
        cur_n   = cur;
        ptr_n   = ptr;
        gs_n    = 1'b0;
        pend_n  = pend | bus.req;
        if (bus.tick) begin
            timer_n = (&timer) ? timer : timer + TW'(1);
            unique case (state)
                ST_ALLRED: begin
                    if (timer >= T_AR) begin
                        state_n = ST_GREEN;
                        timer_n = '0;
                        gs_n    = 1'b1;
                        cur_n   = (bus.peak || !pick_found)
                                  ? ptr : pick_idx;
                        // entry clear beats a same-cycle request
                        for (int i = 0; i < N_PHASE; i++)
                            if (2'(i) == cur_n)
                                pend_n[i] = 1'b0;
                    end
                end
                ST_GREEN: begin
                    if (green_done) begin
                        state_n = ST_YELLOW;
                        timer_n = '0;
                    end
                end
                ST_YELLOW: begin
                    if (timer >= T_Y) begin
                        state_n = ST_ALLRED;
                        timer_n = '0;
                        ptr_n   = ph_add(cur, 1, N_PHASE);
                    end
                end
                default: begin
                    state_n = ST_ALLRED;
                    timer_n = '0;
                end
            endcase
        end
    end

    always_comb begin
        light_n = {N_PHASE{LC_RED}};
        for (int i = 0; i < N_PHASE; i++) begin
            if (2'(i) == cur_n) begin
                unique case (1'b1)
                    (state_n == ST_GREEN):
                        light_n[2*i +: 2] = LC_GREEN;
                    (state_n == ST_YELLOW):
                        light_n[2*i +: 2] = LC_YELLOW;
                    default:
                        light_n[2*i +: 2] = LC_RED;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_ALLRED;
            timer <= '0;
            cur   <= '0;
            ptr   <= '0;
            pend  <= '0;
            gs    <= 1'b0;
            light <= {N_PHASE{LC_RED}};
        end else begin
            state <= state_n;
            timer <= timer_n;
            cur   <= cur_n;
            ptr   <= ptr_n;
            pend  <= pend_n;
            gs    <= gs_n;
            light <= light_n;
        end
    end

    assign bus.light       = light;
    assign bus.cur_phase   = cur;
    assign bus.green_start = gs;
    assign bus.pending     = pend;

endmodule
